add_round_key: RTL and testbench
================================

# add_round_key

Byte-serial AES AddRoundKey stage for the 8-bit-datapath AES core. It accepts a 128-bit state and a 128-bit round key through a valid/ready handshake and XORs them one byte lane group per cycle. It returns the 128-bit result through a second valid/ready handshake. It sits between the round-key schedule and the SubBytes/ShiftRows/MixColumns stages, and serves both the initial key whitening and every round.

## Interface
- LANES, default 1: bytes XORed per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  state_in/round_key valid.
- in_ready  out  1  block can accept a new operand pair.
- state_in  in  128  AES state; byte 0 = bits [127:120], byte 15 = bits [7:0].
- round_key  in  128  round key, same byte ordering.
- out_valid  out  1  state_out holds a completed result.
- out_ready  in  1  downstream accepts the result.
- state_out  out  128  state_in XOR round_key.
- busy  out  1  high while not in IDLE.
- One clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, XOR, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture state_in and round_key into internal work/key registers, clear the byte counter, and go to XOR. Inputs are ignored after capture.
- XOR: each cycle, work bytes [cnt .. cnt+LANES-1] become work_byte ^ key_byte; cnt += LANES. After the cycle processing byte 15, load state_out from the full work register and go to DONE.
- DONE: out_valid=1, state_out held stable. On out_ready, go to IDLE.
- in_ready is 0 in XOR and DONE, so a new operand is never accepted while a result is pending.
- Pure bitwise XOR: no carries, no key expansion, no byte reordering.
- state_out changes only on DONE entry. Between results it holds the last result.
- in_valid asserted while not ready: no effect; upstream must hold until accepted.

## Timing
- Reset values: state_out=0, out_valid=0, in_ready=1 (IDLE), busy=0; work, key and counter registers are 0.
- Latency: handshake at edge N. out_valid rises after edge N+16/LANES (N+16 at LANES=1, N+1 at LANES=16).
- Throughput: one result per 16/LANES+2 cycles when out_ready is held high. DONE lasts at least one cycle.
- out_ready low in DONE: stall indefinitely with out_valid and state_out stable.
- out_ready asserted outside DONE: ignored.
- Reset asserted mid-XOR or mid-DONE: the operation is discarded immediately (asynchronous) and all outputs take reset values. After deassertion the first in_valid is accepted normally.
- The counter is exactly log2(16) bits and must never wrap past byte 15 into a second pass.

## Structure
- Shared package aes_pkg: typedef logic [127:0] aes_state_t; typedef logic [7:0] aes_byte_t; localparam AES_BYTES=16; the FSM state enum.
- One sub-module, ark_lane_xor: LANES-byte-wide XOR slice selected by the counter. The top level holds the FSM, registers and handshakes.

## Test plan
- Basic vector: state_in=00112233445566778899aabbccddeeff, round_key=000102030405060708090a0b0c0d0e0f -> state_out=00102030405060708090a0b0c0d0e0f0 with out_valid 16 cycles after accept (LANES=1).
- FIPS-197 round 0: state 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 193de3bea0f4e22b9ac68d2ae9f84808. Repeat for LANES=1,4,16 and check latency 16/4/1.
- Identity and inversion: key=0 -> state_out=state_in. Key=all-ones with state 00..0ff pattern -> bitwise complement.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and state_out stable, in_ready=0, a new in_valid is not accepted. Release -> IDLE next cycle, then a second vector completes correctly.
- Reset mid-op: assert rst_n=0 at byte 7 -> outputs go to 0/IDLE asynchronously. The next transaction produces the correct result with no residue from the aborted one.
- Back-to-back: in_valid held high with out_ready=1 for 3 random vectors -> 3 correct results, each spaced 18 cycles at LANES=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types for the byte-serial AES datapath.
// Byte 0 of a state is the most significant byte.
package aes_pkg;

    localparam int AES_BYTES = 16;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;
    typedef logic [3:0]   byte_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        XOR,
        DONE
    } ark_state_e;

endpackage

// File: rtl/ark_lane_xor.sv
// XORs the LANES key bytes starting at cnt into the working state.
// Bytes outside the selected group pass through untouched.
module ark_lane_xor
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  aes_state_t work,
    input  aes_state_t key,
    input  byte_idx_t  cnt,
    output aes_state_t result
);

    logic [4:0] base;
    logic [4:0] top;

    assign base = {1'b0, cnt};
    assign top  = base + 5'(LANES);

    for (genvar i = 0; i < AES_BYTES; i++) begin : g_byte
        localparam logic [4:0] IDX = 5'(i);
        logic      sel;
        aes_byte_t w;
        aes_byte_t k;

        assign w   = work[127-8*i -: 8];
        assign k   = key[127-8*i -: 8];
        assign sel = (IDX >= base) && (IDX < top);

        assign result[127-8*i -: 8] = sel ? (w ^ k) : w;
    end

endmodule

// File: rtl/add_round_key.sv
// Byte-serial AES AddRoundKey with valid/ready on both sides.
// One LANES-byte group is folded in per cycle; result held until taken.
module add_round_key
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t state_in,
    input  aes_state_t round_key,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t state_out,
    output logic       busy
);

    localparam byte_idx_t LAST = byte_idx_t'(AES_BYTES - LANES);
    localparam byte_idx_t STEP = byte_idx_t'(LANES);

    ark_state_e state;
    aes_state_t work;
    aes_state_t key;
    aes_state_t lane_res;
    byte_idx_t  cnt;

    ark_lane_xor #(
        .LANES (LANES)
    ) u_lane (
        .work   (work),
        .key    (key),
        .cnt    (cnt),
        .result (lane_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            key       <= '0;
            cnt       <= '0;
            state_out <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= state_in;
                        key      <= round_key;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= XOR;
                    end
                end
                XOR: begin
                    work <= lane_res;
                    // Hold cnt on the final group so it never wraps.
                    if (cnt == LAST) begin
                        state_out <= lane_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_round_key.sv
// Directed bench for add_round_key with a result scoreboard.
// Covers LANES=1 fully plus latency checks at LANES=4 and 16.
module tb_add_round_key;
    import aes_pkg::*;

    localparam aes_state_t BAS_S = 128'h00112233445566778899aabbccddeeff;
    localparam aes_state_t BAS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_state_t BAS_X = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam aes_state_t FIP_S = 128'h3243f6a8885a308d313198a2e0370734;
    localparam aes_state_t FIP_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_state_t FIP_X = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam aes_state_t ONES  = {128{1'b1}};
    localparam aes_state_t CMP_X = 128'hffeeddccbbaa99887766554433221100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    aes_state_t state_in;
    aes_state_t round_key;
    logic       out_valid;
    logic       out_ready;
    aes_state_t state_out;
    logic       busy;

    logic       iv4, ir4, ov4, bz4;
    aes_state_t so4;
    logic       iv16, ir16, ov16, bz16;
    aes_state_t so16;

    int         n_assert = 0;
    int         n_fail = 0;
    int         cyc = 0;
    aes_state_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_round_key #(.LANES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_key (round_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    add_round_key #(.LANES(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .state_in  (state_in),
        .round_key (round_key),
        .out_valid (ov4),
        .out_ready (out_ready),
        .state_out (so4),
        .busy      (bz4)
    );

    add_round_key #(.LANES(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .state_in  (state_in),
        .round_key (round_key),
        .out_valid (ov16),
        .out_ready (out_ready),
        .state_out (so16),
        .busy      (bz16)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle.
    task automatic send(input string tag, input aes_state_t s,
                        input aes_state_t k, input aes_state_t x);
        chk({tag, "_in_ready"}, in_ready, 1);
        state_in  = s;
        round_key = k;
        in_valid  = 1'b1;
        sb.push_back(x);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input int lat_exp);
        int         lat;
        aes_state_t x;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 100);
        chk({tag, "_latency"}, lat, lat_exp);
        x = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk({tag, "_data"}, state_out, x);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_in_ready_done"}, in_ready, 0);
    endtask

    task automatic idle_chk(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_idle_ov"}, out_valid, 0);
        chk({tag, "_idle_ir"}, in_ready, 1);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic lane_run(input int l, input int lat_exp);
        int         lat;
        logic       ov;
        aes_state_t so;
        aes_state_t x;
        state_in  = FIP_S;
        round_key = FIP_K;
        sb.push_back(FIP_X);
        if (l == 4) iv4 = 1'b1;
        else iv16 = 1'b1;
        @(posedge clk);
        #1;
        iv4  = 1'b0;
        iv16 = 1'b0;
        lat  = 0;
        do begin
            @(posedge clk);
            #1 lat++;
            ov = (l == 4) ? ov4 : ov16;
        end while (!ov && lat < 100);
        so = (l == 4) ? so4 : so16;
        x  = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk($sformatf("fips_l%0d_latency", l), lat, lat_exp);
        chk($sformatf("fips_l%0d_data", l), so, x);
        @(posedge clk);
        #1;
        chk($sformatf("fips_l%0d_idle", l), (l == 4) ? ir4 : ir16, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        aes_state_t vs[3];
        aes_state_t vk[3];
        int         t[3];
        int         lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        state_in  = '0;
        round_key = '0;
        iv4       = 1'b0;
        iv16      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_state_out", state_out, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send("basic", BAS_S, BAS_K, BAS_X);
        recv("basic", 16);
        idle_chk("basic");

        send("fips", FIP_S, FIP_K, FIP_X);
        recv("fips", 16);
        idle_chk("fips");
        lane_run(4, 4);
        lane_run(16, 1);

        send("ident", FIP_S, '0, FIP_S);
        recv("ident", 16);
        idle_chk("ident");

        send("compl", BAS_S, ONES, CMP_X);
        recv("compl", 16);
        idle_chk("compl");

        // Stall in DONE while offering a competing operand.
        out_ready = 1'b0;
        send("bp", BAS_S, BAS_K, BAS_X);
        recv("bp", 16);
        state_in  = FIP_S;
        round_key = FIP_K;
        in_valid  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_hold_ov", out_valid, 1);
            chk("bp_hold_data", state_out, BAS_X);
            chk("bp_hold_ir", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle_chk("bp_release");
        chk("bp_release_data", state_out, BAS_X);
        send("bp2", FIP_S, FIP_K, FIP_X);
        recv("bp2", 16);
        idle_chk("bp2");

        // Abort at byte 7.
        send("abort", FIP_S, FIP_K, FIP_X);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ov", out_valid, 0);
        chk("abort_ir", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_state_out", state_out, 0);
        void'(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send("post_abort", BAS_S, ONES, CMP_X);
        recv("post_abort", 16);
        idle_chk("post_abort");

        // Back-to-back with in_valid held high.
        for (int i = 0; i < 3; i++) begin
            vs[i] = {$urandom, $urandom, $urandom, $urandom};
            vk[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        state_in  = vs[0];
        round_key = vk[0];
        in_valid  = 1'b1;
        sb.push_back(vs[0] ^ vk[0]);
        for (int j = 0; j < 3; j++) begin
            lat = 0;
            do begin
                @(posedge clk);
                #1 lat++;
            end while (!out_valid && lat < 40);
            t[j] = cyc;
            chk($sformatf("b2b%0d_seen", j), out_valid, 1);
            chk($sformatf("b2b%0d_data", j), state_out,
                (sb.size() > 0) ? sb.pop_front() : 'x);
            if (j < 2) begin
                state_in  = vs[j+1];
                round_key = vk[j+1];
                sb.push_back(vs[j+1] ^ vk[j+1]);
            end
        end
        in_valid = 1'b0;
        chk("b2b_space01", t[1] - t[0], 18);
        chk("b2b_space12", t[2] - t[1], 18);
        idle_chk("b2b");
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
